instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream sequencer for the datapath decoder stage.
- Reads 24-bit instructions from a synchronous instruction ROM: opcode[23:20], op1[19:16], op2[15:0].
- Holds the instruction stable on the decoder inputs and keeps the decoder in synchronous reset between instructions.
- Releases the decoder for one instruction at a time, waits for its done pulse, then advances the PC. It also handles HALT and an execution watchdog.

Parameters:
- PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W.
- HALT_OP, 4'b1111, opcode that stops fetching; it is never issued to the decoder.
- TIMEOUT, 16, maximum EXEC cycles allowed before dec_done; must be ≥ 8.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin fetching from PC 0; sampled only in IDLE or HALTED.
- imem_addr  out  PC_W  instruction ROM address.
- imem_cs  out  1  ROM read strobe; data is valid on imem_data the cycle after.
- imem_data  in  24  ROM read data.
- opcode  out  4  to decoder; registered, stable through EXEC.
- op1  out  4  to decoder; registered.
- op2  out  16  to decoder; registered.
- dec_rst  out  1  decoder synchronous reset; high except during ISSUE/EXEC.
- dec_done  in  1  decoder completion pulse, 1 cycle.
- pc  out  PC_W  current PC.
- retired  out  CNT_W  count of instructions completed (saturates at all-ones).
- halted  out  1  high in HALTED.
- err_timeout  out  1  sticky; set when the watchdog fires, cleared by rst or start.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pc=0, imem_addr=0, imem_cs=0.
  - opcode/op1/op2=0, dec_rst=1, retired=0, halted=0, err_timeout=0.
- All outputs are registered. The FSM has states IDLE, FETCH, CAPTURE, ISSUE, EXEC, HALTED.
- IDLE: dec_rst=1. On start: pc←0, retired←0, err_timeout←0, go to FETCH.
- FETCH (1 cycle): imem_cs=1, imem_addr=pc, go to CAPTURE.
- CAPTURE (1 cycle): imem_cs=0.
  - Latch opcode/op1/op2 from imem_data.
  - If imem_data[23:20]==HALT_OP, go to HALTED; the opcode registers still update so the bench can see the HALT word.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): dec_rst←0, watchdog counter←0, go to EXEC.
  - dec_rst is therefore high for at least 2 cycles before each release: FETCH and CAPTURE.
- EXEC: dec_rst=0; opcode/op1/op2 held constant; watchdog increments each cycle.
  - On dec_done=1: dec_rst←1, pc←pc+1 (wrap from 2^PC_W−1 to 0), retired←retired+1 (saturating), go to FETCH.
  - When watchdog reaches TIMEOUT with no dec_done: dec_rst←1, err_timeout←1, go to HALTED; pc is not advanced.
  - dec_done and the timeout in the same cycle: done wins, no error.
- HALTED: halted=1, dec_rst=1, pc frozen. On start, behave exactly as from IDLE.
- Ignored inputs:
  - dec_done outside EXEC is ignored.
  - start outside IDLE/HALTED is ignored.
- Instruction cadence: FETCH, CAPTURE and ISSUE take 3 cycles. The decoder then takes 6 cycles from release to done. A normal instruction therefore takes 9 cycles from FETCH to the next FETCH.
- rst asserted mid-EXEC: everything returns to the reset values immediately and dec_rst goes high asynchronously.
- PC wrap is legal; no error is raised.

Decomposition:
- Shared package:
  - state enum (IDLE, FETCH, CAPTURE, ISSUE, EXEC, HALTED).
  - HALT_OP and the load-immediate opcode constant 4'b0111.
  - instruction field bit positions (OPC_HI=23, OPC_LO=20, OP1_HI=19, OP1_LO=16).
- Sub-module: instr_watchdog, a loadable cycle counter with a terminal-count flag, parameterised by TIMEOUT.
- The FSM, PC and retired counter stay in the top level.

Test Plan:
- Basic run:
  - Stimulus: ROM[0]=24'h1_3_0004, ROM[1]=24'hF00000; the decoder model pulses done 6 cycles after release; pulse start.
  - Required: opcode=1, op1=3, op2=4 held through EXEC; retired=1; pc=1; halted=1 after CAPTURE of ROM[1]; dec_rst never low for the HALT word.
- Load-immediate sequence:
  - Stimulus: ROM[0..2]=24'h7_2_00AA, 24'h7_5_0055, 24'hF00000.
  - Required: two ISSUE pulses; retired=2; 9 cycles between successive FETCHes.
- Watchdog:
  - Stimulus: decoder model never asserts done.
  - Required: err_timeout=1 and halted=1 exactly TIMEOUT=16 EXEC cycles after ISSUE; pc=0; retired=0.
- Watchdog tie:
  - Stimulus: done arrives on the same cycle as the terminal count.
  - Required: err_timeout=0; pc advances.
- PC wrap:
  - Stimulus: PC_W=2; ROM of four non-HALT words.
  - Required: pc sequence 0,1,2,3,0; retired=4 after the fourth done; no error.
- Reset mid-EXEC:
  - Stimulus: assert rst 2 cycles into EXEC.
  - Required: dec_rst=1, pc=0, retired=0, opcode=0 in the same cycle (async); a subsequent start refetches ROM[0].

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the opcode constants and the instruction field layout.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_LDI  = 4'b0111;

  localparam int INSTR_W = 24;
  localparam int OPC_HI  = 23;
  localparam int OPC_LO  = 20;
  localparam int OP1_HI  = 19;
  localparam int OP1_LO  = 16;

endpackage

// File: rtl/instr_watchdog.sv
// Execution watchdog: cleared on load, counts enabled cycles, and flags the last allowed cycle.
// tc is combinational so the sequencer can act on the same edge the limit is reached.
module instr_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Holds at LAST so a late-arriving done never sees a wrapped count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Fetches one ROM word at a time, holds it on the decoder inputs and releases the decoder
// until its done pulse; stops on HALT or when the execution watchdog expires.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int         PC_W    = 8,
  parameter logic [3:0] HALT_OP = OP_HALT,
  parameter int         TIMEOUT = 16,
  parameter int         CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_cs,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [3:0]         opcode,
  output logic [3:0]         op1,
  output logic [15:0]        op2,
  output logic               dec_rst,
  input  logic               dec_done,
  output logic [PC_W-1:0]    pc,
  output logic [CNT_W-1:0]   retired,
  output logic               halted,
  output logic               err_timeout
);

  state_t            st, nxt;
  logic [PC_W-1:0]   pc_d;
  logic [CNT_W-1:0]  ret_d;
  logic              err_d;
  logic              wd_load, wd_en, wd_tc;

  instr_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk  (clk),
    .rst  (rst),
    .load (wd_load),
    .en   (wd_en),
    .tc   (wd_tc)
  );

  always_comb begin
    nxt     = st;
    pc_d    = pc;
    ret_d   = retired;
    err_d   = err_timeout;
    wd_load = 1'b0;
    wd_en   = 1'b0;
    case (st)
      S_IDLE, S_HALTED: begin
        if (start) begin
          nxt   = S_FETCH;
          pc_d  = '0;
          ret_d = '0;
          err_d = 1'b0;
        end
      end
      S_FETCH:   nxt = S_CAPTURE;
      S_CAPTURE: nxt = (imem_data[OPC_HI:OPC_LO] == HALT_OP) ? S_HALTED : S_ISSUE;
      S_ISSUE: begin
        nxt     = S_EXEC;
        wd_load = 1'b1;
      end
      S_EXEC: begin
        wd_en = 1'b1;
        // done takes priority over a watchdog expiry on the same cycle
        if (dec_done) begin
          nxt  = S_FETCH;
          pc_d = pc + 1'b1;
          if (retired != '1) ret_d = retired + 1'b1;
        end else if (wd_tc) begin
          nxt   = S_HALTED;
          err_d = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      pc          <= '0;
      imem_addr   <= '0;
      imem_cs     <= 1'b0;
      opcode      <= '0;
      op1         <= '0;
      op2         <= '0;
      dec_rst     <= 1'b1;
      retired     <= '0;
      halted      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      st          <= nxt;
      pc          <= pc_d;
      imem_addr   <= pc_d;
      retired     <= ret_d;
      err_timeout <= err_d;
      imem_cs     <= (nxt == S_FETCH);
      dec_rst     <= !((nxt == S_ISSUE) || (nxt == S_EXEC));
      halted      <= (nxt == S_HALTED);
      if (st == S_CAPTURE) begin
        opcode <= imem_data[OPC_HI:OPC_LO];
        op1    <= imem_data[OP1_HI:OP1_LO];
        op2    <= imem_data[OP1_LO-1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: ROM and decoder models plus an issue scoreboard.
// A second instance with a 2-bit PC covers address wrap.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [23:0] w;
    logic [7:0]  pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  imem_addr, pc;
  logic        imem_cs, dec_rst, halted, err_timeout;
  logic [23:0] imem_data = 24'h0;
  logic        dec_done = 1'b0;
  logic [3:0]  opcode, op1;
  logic [15:0] op2, retired;

  logic [1:0]  imem_addr2, pc2;
  logic        imem_cs2, dec_rst2, halted2, err_timeout2;
  logic [23:0] imem_data2 = 24'h0;
  logic        dec_done2 = 1'b0;
  logic [3:0]  opcode2, op12;
  logic [15:0] op22, retired2;

  instr_fetch #(.PC_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_cs(imem_cs),
    .imem_data(imem_data), .opcode(opcode), .op1(op1), .op2(op2), .dec_rst(dec_rst),
    .dec_done(dec_done), .pc(pc), .retired(retired), .halted(halted), .err_timeout(err_timeout)
  );

  instr_fetch #(.PC_W(2), .TIMEOUT(TIMEOUT)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .imem_addr(imem_addr2), .imem_cs(imem_cs2),
    .imem_data(imem_data2), .opcode(opcode2), .op1(op12), .op2(op22), .dec_rst(dec_rst2),
    .dec_done(dec_done2), .pc(pc2), .retired(retired2), .halted(halted2), .err_timeout(err_timeout2)
  );

  logic [23:0] rom [256];
  logic [23:0] rom2 [4];
  exp_t sb[$];
  exp_t sb2[$];
  int   fetch_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   lat = 6;
  int   issue_cnt = 0;
  int   issue_cnt2 = 0;

  logic        cs_q1 = 1'b0, prev_rst1 = 1'b1, cs_q2 = 1'b0, prev_rst2 = 1'b1;
  logic [7:0]  addr_q1 = 8'd0;
  logic [1:0]  addr_q2 = 2'd0;
  int          rel1 = 0, rel2 = 0;
  logic [23:0] cur1 = 24'd0, cur2 = 24'd0;
  exp_t        e1, e2;

  // ROM, decoder and issue monitor for the main instance (lat = EXEC cycles until done, 0 = never)
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      imem_data = cs_q1 ? rom[addr_q1] : 24'hD0DEAD;
      cs_q1 = imem_cs;
      addr_q1 = imem_addr;
      rel1 = dec_rst ? 0 : rel1 + 1;
      dec_done = (lat != 0) && (rel1 == lat + 1);
      if (imem_cs) fetch_q.push_back(cyc);
      if (!dec_rst && prev_rst1) begin
        issue_cnt++;
        checks++;
        cur1 = {opcode, op1, op2};
        if (sb.size() == 0) begin
          $display("FAIL issue_unexpected: word %h pc %0d issued, none expected", cur1, pc);
        end else begin
          e1 = sb.pop_front();
          if (cur1 === e1.w && pc === e1.pc) passed++;
          else $display("FAIL issue: word %h pc %0d, expected word %h pc %0d", cur1, pc, e1.w, e1.pc);
        end
      end
      if (dec_done) begin
        checks++;
        if ({opcode, op1, op2} === cur1) passed++;
        else $display("FAIL hold: word %h at done, expected %h", {opcode, op1, op2}, cur1);
      end
      prev_rst1 = dec_rst;
    end
  end

  // Same models for the 2-bit PC instance; its decoder always answers after 6 EXEC cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      imem_data2 = cs_q2 ? rom2[addr_q2] : 24'hD0DEAD;
      cs_q2 = imem_cs2;
      addr_q2 = imem_addr2;
      rel2 = dec_rst2 ? 0 : rel2 + 1;
      dec_done2 = (rel2 == 7);
      if (!dec_rst2 && prev_rst2) begin
        issue_cnt2++;
        checks++;
        cur2 = {opcode2, op12, op22};
        if (sb2.size() == 0) begin
          $display("FAIL issue2_unexpected: word %h pc %0d issued, none expected", cur2, pc2);
        end else begin
          e2 = sb2.pop_front();
          if (cur2 === e2.w && 8'(pc2) === e2.pc) passed++;
          else $display("FAIL issue2: word %h pc %0d, expected word %h pc %0d", cur2, pc2, e2.w, e2.pc);
        end
      end
      prev_rst2 = dec_rst2;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [23:0] w, input logic [7:0] p);
    exp_t e;
    e.w = w;
    e.pc = p;
    sb.push_back(e);
  endtask

  task automatic push_exp2(input logic [23:0] w, input logic [7:0] p);
    exp_t e;
    e.w = w;
    e.pc = p;
    sb2.push_back(e);
  endtask

  task automatic wait_halted(input int budget, input string name);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin tick(1); n++; end
    checks++;
    if (halted === 1'b1) passed++;
    else $display("FAIL %s_halt_wait: halted=%b after %0d cycles, expected 1", name, halted, budget);
  endtask

  task automatic test_reset;
    checks++;
    if (pc === 8'd0 && imem_addr === 8'd0 && imem_cs === 1'b0) passed++;
    else $display("FAIL reset_fetch: pc=%h addr=%h cs=%b, expected 0/0/0", pc, imem_addr, imem_cs);
    checks++;
    if ({opcode, op1, op2} === 24'd0 && dec_rst === 1'b1) passed++;
    else $display("FAIL reset_dec: word=%h dec_rst=%b, expected 000000/1", {opcode, op1, op2}, dec_rst);
    checks++;
    if (retired === 16'd0 && halted === 1'b0 && err_timeout === 1'b0) passed++;
    else $display("FAIL reset_status: retired=%0d halted=%b err=%b, expected 0/0/0", retired, halted, err_timeout);
    checks++;
    if (pc2 === 2'd0 && dec_rst2 === 1'b1 && imem_cs2 === 1'b0) passed++;
    else $display("FAIL reset_dut2: pc=%h dec_rst=%b cs=%b, expected 0/1/0", pc2, dec_rst2, imem_cs2);
  endtask

  task automatic test_basic;
    rom[0] = 24'h130004;
    rom[1] = 24'hF00000;
    lat = 6;
    issue_cnt = 0;
    push_exp(24'h130004, 8'd0);
    pulse_start();
    wait_halted(60, "basic");
    checks++;
    if (retired === 16'd1 && pc === 8'd1) passed++;
    else $display("FAIL basic_count: retired=%0d pc=%0d, expected 1/1", retired, pc);
    checks++;
    if ({opcode, op1, op2} === 24'hF00000) passed++;
    else $display("FAIL basic_haltword: word=%h, expected F00000", {opcode, op1, op2});
    checks++;
    if (issue_cnt === 1 && dec_rst === 1'b1 && err_timeout === 1'b0) passed++;
    else $display("FAIL basic_noissue_halt: issues=%0d dec_rst=%b err=%b, expected 1/1/0", issue_cnt, dec_rst, err_timeout);
  endtask

  task automatic test_ldi;
    rom[0] = {OP_LDI, 4'h2, 16'h00AA};
    rom[1] = {OP_LDI, 4'h5, 16'h0055};
    rom[2] = 24'hF00000;
    lat = 6;
    issue_cnt = 0;
    fetch_q.delete();
    push_exp({OP_LDI, 4'h2, 16'h00AA}, 8'd0);
    push_exp({OP_LDI, 4'h5, 16'h0055}, 8'd1);
    pulse_start();
    wait_halted(80, "ldi");
    checks++;
    if (retired === 16'd2 && issue_cnt === 2) passed++;
    else $display("FAIL ldi_count: retired=%0d issues=%0d, expected 2/2", retired, issue_cnt);
    checks++;
    if (fetch_q.size() == 3 && fetch_q[1] - fetch_q[0] == 9 && fetch_q[2] - fetch_q[1] == 9) passed++;
    else $display("FAIL ldi_cadence: %0d fetches at %p, expected 3 fetches 9 cycles apart", fetch_q.size(), fetch_q);
  endtask

  task automatic test_watchdog;
    int n = 0;
    rom[0] = {OP_LDI, 4'h1, 16'h1234};
    rom[1] = 24'hF00000;
    lat = 0;
    push_exp({OP_LDI, 4'h1, 16'h1234}, 8'd0);
    pulse_start();
    while (dec_rst !== 1'b0 && n < 20) begin tick(1); n++; end
    checks++;
    if (dec_rst === 1'b0) passed++;
    else $display("FAIL wd_issue: dec_rst=%b after 20 cycles, expected 0", dec_rst);
    tick(TIMEOUT);
    checks++;
    if (halted === 1'b0 && err_timeout === 1'b0) passed++;
    else $display("FAIL wd_early: halted=%b err=%b after %0d EXEC cycles, expected 0/0", halted, err_timeout, TIMEOUT - 1);
    tick(1);
    checks++;
    if (halted === 1'b1 && err_timeout === 1'b1) passed++;
    else $display("FAIL wd_fire: halted=%b err=%b after %0d EXEC cycles, expected 1/1", halted, err_timeout, TIMEOUT);
    checks++;
    if (pc === 8'd0 && retired === 16'd0 && dec_rst === 1'b1) passed++;
    else $display("FAIL wd_state: pc=%0d retired=%0d dec_rst=%b, expected 0/0/1", pc, retired, dec_rst);
  endtask

  task automatic test_tie;
    rom[0] = 24'h240F0F;
    rom[1] = 24'hF00000;
    lat = TIMEOUT;
    push_exp(24'h240F0F, 8'd0);
    pulse_start();
    checks++;
    if (err_timeout === 1'b0) passed++;
    else $display("FAIL tie_err_clear: err=%b after start, expected 0", err_timeout);
    wait_halted(80, "tie");
    checks++;
    if (err_timeout === 1'b0 && pc === 8'd1 && retired === 16'd1) passed++;
    else $display("FAIL tie_done_wins: err=%b pc=%0d retired=%0d, expected 0/1/1", err_timeout, pc, retired);
  endtask

  task automatic test_pc_wrap;
    int n = 0;
    for (int i = 0; i < 4; i++) rom2[i] = {4'(i + 1), 4'(i + 1), 16'(i + 1)};
    for (int i = 0; i < 5; i++) push_exp2(rom2[i % 4], 8'(i % 4));
    issue_cnt2 = 0;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    while (retired2 !== 16'd4 && n < 80) begin tick(1); n++; end
    checks++;
    if (retired2 === 16'd4 && pc2 === 2'd0) passed++;
    else $display("FAIL wrap_pc: retired=%0d pc=%0d, expected 4/0", retired2, pc2);
    checks++;
    if (err_timeout2 === 1'b0 && halted2 === 1'b0) passed++;
    else $display("FAIL wrap_status: err=%b halted=%b, expected 0/0", err_timeout2, halted2);
    n = 0;
    while (issue_cnt2 < 5 && n < 20) begin tick(1); n++; end
    tick(1);
    checks++;
    if (issue_cnt2 === 5 && sb2.size() == 0) passed++;
    else $display("FAIL wrap_issues: issues=%0d pending=%0d, expected 5/0", issue_cnt2, sb2.size());
    do_reset();
  endtask

  task automatic test_reset_mid;
    int n = 0;
    rom[0] = {OP_LDI, 4'h3, 16'hBEEF};
    rom[1] = 24'h561357;
    rom[2] = 24'hF00000;
    lat = 6;
    push_exp({OP_LDI, 4'h3, 16'hBEEF}, 8'd0);
    push_exp(24'h561357, 8'd1);
    pulse_start();
    while (!(pc === 8'd1 && dec_rst === 1'b0) && n < 40) begin tick(1); n++; end
    tick(2);
    checks++;
    if (opcode === 4'h5 && retired === 16'd1 && dec_rst === 1'b0) passed++;
    else $display("FAIL mid_pre: opcode=%h retired=%0d dec_rst=%b, expected 5/1/0", opcode, retired, dec_rst);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dec_rst === 1'b1 && pc === 8'd0 && retired === 16'd0) passed++;
    else $display("FAIL mid_async: dec_rst=%b pc=%0d retired=%0d, expected 1/0/0", dec_rst, pc, retired);
    checks++;
    if ({opcode, op1, op2} === 24'd0 && imem_cs === 1'b0) passed++;
    else $display("FAIL mid_async_word: word=%h cs=%b, expected 000000/0", {opcode, op1, op2}, imem_cs);
    tick(1);
    rst = 1'b0;
    push_exp({OP_LDI, 4'h3, 16'hBEEF}, 8'd0);
    push_exp(24'h561357, 8'd1);
    pulse_start();
    wait_halted(80, "mid_restart");
    checks++;
    if (retired === 16'd2 && sb.size() == 0) passed++;
    else $display("FAIL mid_restart: retired=%0d pending=%0d, expected 2/0", retired, sb.size());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 24'hF00000;
    for (int i = 0; i < 4; i++) rom2[i] = 24'h100001;
    do_reset();
    test_reset();
    test_basic();
    test_ldi();
    test_watchdog();
    test_tie();
    test_pc_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
